// File: rtl/pc_fetch_unit.sv
// Program counter, instruction register and 8-deep call stack for the fetch
// stage. The PC drives program memory directly; the instruction register
// captures the synchronous ROM output one cycle later.
module pc_fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_rd_en,
  input  logic        instr_flush,
  input  logic        pc_incr_en,
  input  logic        pc_j_en,
  input  logic        pc_call_en,
  input  logic        pc_ret_en,
  input  logic        pcl_wr_en,
  input  logic [7:0]  pcl_wdata,
  input  logic [4:0]  pclath,
  input  logic [13:0] pm_rdata,
  output logic [12:0] pm_addr,
  output logic [13:0] instr_current,
  output logic [7:0]  pcl,
  output logic [2:0]  stk_ptr,
  output logic        stk_ovf,
  output logic        stk_unf
);

  localparam int unsigned STK_DEPTH = 8;

  typedef enum logic [2:0] {
    SRC_HOLD,
    SRC_INC,
    SRC_JMP,
    SRC_CALL,
    SRC_RET,
    SRC_PCL
  } pc_src_e;

  pc_src_e     pc_src;

  logic [12:0] pc_q, pc_d;
  logic [13:0] ir_q, ir_d;
  logic [2:0]  stk_ptr_q, stk_ptr_d;
  logic [3:0]  depth_q, depth_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;
  logic [12:0] stack_q [STK_DEPTH];
  logic [12:0] stack_d [STK_DEPTH];

  logic [2:0]  pop_idx;
  logic [12:0] jmp_target;

  // Pick the single highest-priority PC source for this edge
  always_comb begin
    pc_src = SRC_HOLD;
    if (pcl_wr_en)       pc_src = SRC_PCL;
    else if (pc_ret_en)  pc_src = SRC_RET;
    else if (pc_call_en) pc_src = SRC_CALL;
    else if (pc_j_en)    pc_src = SRC_JMP;
    else if (pc_incr_en) pc_src = SRC_INC;
  end

  // Next-state for PC, stack and sticky flags; stack side effects follow pc_src only
  always_comb begin
    pop_idx    = stk_ptr_q - 3'd1;
    jmp_target = {pclath[4:3], ir_q[10:0]};
    pc_d       = pc_q;
    stk_ptr_d  = stk_ptr_q;
    depth_d    = depth_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    for (int unsigned i = 0; i < STK_DEPTH; i++) begin
      stack_d[i] = stack_q[i];
    end

    unique case (pc_src)
      SRC_PCL:  pc_d = {pclath, pcl_wdata};
      SRC_RET: begin
        pc_d      = stack_q[pop_idx];
        stk_ptr_d = pop_idx;
        if (depth_q == 4'd0) unf_d   = 1'b1;
        else                 depth_d = depth_q - 4'd1;
      end
      SRC_CALL: begin
        stack_d[stk_ptr_q] = pc_q;
        stk_ptr_d          = stk_ptr_q + 3'd1;
        pc_d               = jmp_target;
        if (depth_q == 4'(STK_DEPTH)) ovf_d   = 1'b1;
        else                          depth_d = depth_q + 4'd1;
      end
      SRC_JMP:  pc_d = jmp_target;
      SRC_INC:  pc_d = pc_q + 13'd1;
      SRC_HOLD: pc_d = pc_q;
      default:  pc_d = pc_q;
    endcase
  end

  // Instruction register: flush beats a ROM load
  always_comb begin
    ir_d = ir_q;
    if (instr_flush)      ir_d = '0;
    else if (instr_rd_en) ir_d = pm_rdata;
  end

  // State registers; reset is asynchronous and clears everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= '0;
      ir_q      <= '0;
      stk_ptr_q <= '0;
      depth_q   <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      for (int unsigned i = 0; i < STK_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      stk_ptr_q <= stk_ptr_d;
      depth_q   <= depth_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      for (int unsigned i = 0; i < STK_DEPTH; i++) begin
        stack_q[i] <= stack_d[i];
      end
    end
  end

  assign pm_addr       = pc_q;
  assign pcl           = pc_q[7:0];
  assign instr_current = ir_q;
  assign stk_ptr       = stk_ptr_q;
  assign stk_ovf       = ovf_q;
  assign stk_unf       = unf_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with hand-computed expectations.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_rd_en, instr_flush, pc_incr_en, pc_j_en;
  logic        pc_call_en, pc_ret_en, pcl_wr_en;
  logic [7:0]  pcl_wdata;
  logic [4:0]  pclath;
  logic [13:0] pm_rdata;
  logic [12:0] pm_addr;
  logic [13:0] instr_current;
  logic [7:0]  pcl;
  logic [2:0]  stk_ptr;
  logic        stk_ovf, stk_unf;

  int nvec = 0;
  int nerr = 0;

  pc_fetch_unit dut (
    .clk(clk), .rst(rst),
    .instr_rd_en(instr_rd_en), .instr_flush(instr_flush),
    .pc_incr_en(pc_incr_en), .pc_j_en(pc_j_en),
    .pc_call_en(pc_call_en), .pc_ret_en(pc_ret_en),
    .pcl_wr_en(pcl_wr_en), .pcl_wdata(pcl_wdata), .pclath(pclath),
    .pm_rdata(pm_rdata), .pm_addr(pm_addr), .instr_current(instr_current),
    .pcl(pcl), .stk_ptr(stk_ptr), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    instr_rd_en = 0; instr_flush = 0; pc_incr_en = 0; pc_j_en = 0;
    pc_call_en = 0; pc_ret_en = 0; pcl_wr_en = 0;
  endtask

  // Apply current inputs for one rising edge, then sample 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    pcl_wdata = 8'h00; pclath = 5'h00; pm_rdata = 14'h0000;
    rst = 1'b1;
    #1;
    chk("rst_pc", 16'(pm_addr), 16'h0000);
    chk("rst_ir", 16'(instr_current), 16'h0000);
    chk("rst_ptr", 16'(stk_ptr), 16'h0000);
    chk("rst_flags", 16'({stk_ovf, stk_unf}), 16'h0000);
    // inputs ignored while reset held across an edge
    pc_incr_en = 1; instr_rd_en = 1; pm_rdata = 14'h1111;
    @(posedge clk); #1;
    chk("rst_hold_pc", 16'(pm_addr), 16'h0000);
    chk("rst_hold_ir", 16'(instr_current), 16'h0000);
    idle();
    rst = 1'b0;

    // fetch + increment
    pm_rdata = 14'h3005; instr_rd_en = 1; pc_incr_en = 1;
    tick();
    chk("fetch_ir", 16'(instr_current), 16'h3005);
    chk("fetch_pc", 16'(pm_addr), 16'h0001);
    chk("fetch_pcl", 16'(pcl), 16'h0001);

    // goto with flush: target from old IR
    pm_rdata = 14'h2823; instr_rd_en = 1;
    tick();
    chk("ld_goto_ir", 16'(instr_current), 16'h2823);
    chk("ld_goto_pc", 16'(pm_addr), 16'h0001);
    pclath = 5'b11000; pc_j_en = 1; instr_flush = 1;
    tick();
    chk("goto_pc", 16'(pm_addr), 16'h1823);
    chk("goto_ir", 16'(instr_current), 16'h0000);

    // flush beats rd_en
    pm_rdata = 14'h3FFF; instr_rd_en = 1; instr_flush = 1;
    tick();
    chk("flush_prio_ir", 16'(instr_current), 16'h0000);

    // wrap at 0x1FFF
    pclath = 5'h1F; pcl_wdata = 8'hFF; pcl_wr_en = 1;
    tick();
    chk("pcl_wr_pc", 16'(pm_addr), 16'h1FFF);
    pc_incr_en = 1;
    tick();
    chk("wrap_pc", 16'(pm_addr), 16'h0000);
    chk("wrap_flags", 16'({stk_ovf, stk_unf}), 16'h0000);

    // nine calls from 0x010..0x018, each to 0x100
    pm_rdata = 14'h2100; instr_rd_en = 1;
    tick();
    pclath = 5'h00;
    for (int i = 0; i < 9; i++) begin
      pcl_wdata = 8'(8'h10 + i); pcl_wr_en = 1;
      tick();
      chk("call_src_pc", 16'(pm_addr), 16'(16'h0010 + i));
      pc_call_en = 1; pc_j_en = 1; pc_incr_en = 1;
      tick();
      chk("call_pc", 16'(pm_addr), 16'h0100);
      chk("call_ptr", 16'(stk_ptr), 16'((i + 1) % 8));
      chk("call_ovf", 16'(stk_ovf), (i == 8) ? 16'h1 : 16'h0);
    end

    // eight rets unwind LIFO; entry 0x010 was overwritten
    for (int k = 1; k <= 8; k++) begin
      pc_ret_en = 1; pc_call_en = 1;
      tick();
      chk("ret_pc", 16'(pm_addr), 16'(16'h0019 - k));
      chk("ret_ptr", 16'(stk_ptr), 16'((9 - k) % 8));
      chk("ret_unf", 16'(stk_unf), 16'h0000);
    end
    // ninth ret underflows and reads stale slot 0
    pc_ret_en = 1;
    tick();
    chk("unf_pc", 16'(pm_addr), 16'h0018);
    chk("unf_ptr", 16'(stk_ptr), 16'h0000);
    chk("unf_flags", 16'({stk_ovf, stk_unf}), 16'h0003);

    // pcl write beats ret and incr, stack untouched
    pclath = 5'h02; pcl_wdata = 8'h40; pcl_wr_en = 1; pc_ret_en = 1; pc_incr_en = 1;
    tick();
    chk("prio_pc", 16'(pm_addr), 16'h0240);
    chk("prio_ptr", 16'(stk_ptr), 16'h0000);

    // asynchronous reset mid-cycle
    pclath = 5'h01; pcl_wdata = 8'h55; pcl_wr_en = 1; pm_rdata = 14'h1234; instr_rd_en = 1;
    tick();
    chk("pre_arst_pc", 16'(pm_addr), 16'h0155);
    chk("pre_arst_ir", 16'(instr_current), 16'h1234);
    #2 rst = 1'b1;
    #1;
    chk("arst_pc", 16'(pm_addr), 16'h0000);
    chk("arst_ir", 16'(instr_current), 16'h0000);
    chk("arst_ptr", 16'(stk_ptr), 16'h0000);
    chk("arst_flags", 16'({stk_ovf, stk_unf}), 16'h0000);
    pc_incr_en = 1;
    tick();
    chk("arst_hold_pc", 16'(pm_addr), 16'h0000);
    rst = 1'b0;
    pm_rdata = 14'h0ABC; instr_rd_en = 1; pc_incr_en = 1;
    tick();
    chk("post_rst_ir", 16'(instr_current), 16'h0ABC);
    chk("post_rst_pc", 16'(pm_addr), 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 instr_rd_en  in  1  load instruction register from program memory data.
REQ-005 instr_flush  in  1  load NOP (14'h0000) into instruction register.
REQ-006 pc_incr_en  in  1  PC <= PC+1.
REQ-007 pc_j_en  in  1  goto: PC <= {pclath[4:3], instr_current[10:0]}.
REQ-008 pc_call_en  in  1  push PC onto stack, then load as for goto.
REQ-009 pc_ret_en  in  1  pop stack top into PC (return/retlw/retfie).
REQ-010 pcl_wr_en  in  1  computed jump: PC <= {pclath[4:0], pcl_wdata}.
REQ-011 pcl_wdata  in  8  new PCL value.
REQ-012 pclath  in  5  PCLATH register contents.
REQ-013 pm_rdata  in  14  program memory read data; synchronous ROM, 1-cycle latency from pm_addr.
REQ-014 pm_addr  out  13  program memory address; equals PC register, no combinational path from inputs.
REQ-015 instr_current  out  14  instruction register, fed to the decoder.
REQ-016 pcl  out  8  PC[7:0], for PCL reads.
REQ-017 stk_ptr  out  3  stack write pointer (next free slot).
REQ-018 stk_ovf  out  1  sticky: push while stack held 8 entries.
REQ-019 stk_unf  out  1  sticky: pop while stack held 0 entries.

Function
REQ-020 PC is a 13-bit register holding the address of the next instruction to fetch; all updates take effect on the rising clk edge.
REQ-021 PC update priority per edge: pcl_wr_en > pc_ret_en > pc_call_en > pc_j_en > pc_incr_en; only the highest asserted source acts, lower ones ignored, including their stack side effects.
REQ-022 Increment wraps 13'h1FFF -> 13'h0000, no flag.
REQ-023 Instruction register: instr_flush loads 14'h0000; else instr_rd_en loads pm_rdata; else holds. Flush wins when both are asserted.
REQ-024 IR load and PC update on the same edge use the pre-edge values: IR gets data for the old PC; goto/call targets use the old instr_current.
REQ-025 Stack: 8 x 13-bit circular array, stk_ptr 3-bit, internal depth counter 0..8.
REQ-026 Push (call): stack[stk_ptr] <= PC (old value, i.e. return address), stk_ptr <= stk_ptr+1 mod 8; depth increments, saturating at 8.
REQ-027 Push at depth 8: overwrite oldest entry per REQ-026, stk_ptr wraps, stk_ovf <= 1.
REQ-028 Pop (ret): PC <= stack[stk_ptr-1 mod 8], stk_ptr <= stk_ptr-1 mod 8; depth decrements, saturating at 0.
REQ-029 Pop at depth 0: still performed per REQ-028 (wrapped, stale data), stk_unf <= 1.
REQ-030 stk_ovf and stk_unf clear only on reset.
REQ-031 pm_addr is stable for at least 1 cycle before any instr_rd_en edge under the decoder's 4-cycle Q sequence; the unit does not check for this.

Reset
REQ-032 rst asserted, with no clock edge needed: PC=0, pm_addr=0, instr_current=14'h0000 (NOP), stk_ptr=0, depth=0, stk_ovf=0, stk_unf=0; stack array contents are don't-care.
REQ-033 Reset mid-operation aborts any update on that edge; the first instruction fetched after release is from address 0.
REQ-034 Reset release is synchronous to clk for internal removal; all inputs are ignored while rst=1.

Verification
REQ-035 Reset, then pm_rdata=14'h3005 with instr_rd_en+pc_incr_en pulse -> instr_current=14'h3005, PC=1.
REQ-036 PC=13'h1FFF, pc_incr_en -> PC=0, no flag change.
REQ-037 instr_current=14'h2823 (goto 0x023), pclath=5'b11000, pc_j_en+instr_flush -> PC=13'h1823, instr_current=0.
REQ-038 Nine calls from PC=0x010.., then nine rets -> stk_ovf=1 after 9th call; the first 8 rets return the last 8 addresses in LIFO order; the 9th ret sets stk_unf=1.
REQ-039 pcl_wr_en, pc_ret_en and pc_incr_en asserted together, pclath=5'h02, pcl_wdata=8'h40 -> PC=13'h0240, stk_ptr unchanged.
REQ-040 rst pulsed asynchronously between clock edges while PC=0x155 -> PC=0 and instr_current=0 immediately, before the next edge.
